// File: rtl/std_mem_d1_loader_pkg.sv
// Shared types for the std_mem_d1 preload front-end.
package std_mem_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    WRITE     = 3'd2,
    WAIT_DONE = 3'd3,
    FINISH    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/std_mem_d1_loader_if.sv
// Control, stream and memory write-port bundle around the loader.
// master = the loader itself, slave = its surroundings (caller, source, memory).
interface std_mem_d1_loader_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic                go;
  logic [IDX_SIZE:0]   len;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_write_data;
  logic                mem_write_en;
  logic                mem_done;
  logic                done;
  logic                busy;
  logic                len_err;

  modport master (
    input  go, len, in_data, in_valid, mem_done,
    output in_ready, mem_addr0, mem_write_data, mem_write_en, done, busy, len_err
  );

  modport slave (
    output go, len, in_data, in_valid, mem_done,
    input  in_ready, mem_addr0, mem_write_data, mem_write_en, done, busy, len_err
  );
endinterface

// File: rtl/std_mem_d1.sv
// One-dimensional memory primitive: registered write, done flag one cycle after write_en.
module std_mem_d1 #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done
);
  logic [WIDTH-1:0] mem [SIZE];

  assign read_data = mem[addr0];

  // done echoes the write strobe one cycle later
  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= write_en;
  end

  // storage array, no reset
  always_ff @(posedge clk) begin
    if (write_en) mem[addr0] <= write_data;
  end
endmodule

// File: rtl/std_mem_d1_loader.sv
// Streams words into a std_mem_d1 at addresses 0..eff_len-1 under go/done control.
module std_mem_d1_loader
  import std_mem_loader_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  std_mem_d1_loader_if.master  bus
);
  localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0] ONE_W  = (IDX_SIZE+1)'(1);

  loader_state_t     r_state, w_state_nxt;
  logic [IDX_SIZE:0] r_idx, r_len;
  logic [IDX_SIZE:0] w_eff_len, w_idx_inc;
  logic [WIDTH-1:0]  r_data;
  logic              r_len_err, w_len_over;

  // idx is one bit wider than the address so it can reach eff_len == SIZE
  assign w_len_over = (bus.len > SIZE_W);
  assign w_eff_len  = w_len_over ? SIZE_W : bus.len;
  assign w_idx_inc  = r_idx + ONE_W;

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // next-state logic; stalls on in_valid and mem_done are unbounded
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (bus.go) w_state_nxt = (w_eff_len == '0) ? FINISH : WAIT_DATA;
      WAIT_DATA: if (bus.in_valid) w_state_nxt = WRITE;
      WRITE:     w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.mem_done) w_state_nxt = (w_idx_inc == r_len) ? FINISH : WAIT_DATA;
      FINISH:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // length/index/data registers; len_err is refreshed only by an accepted go
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.go) begin
        r_len     <= w_eff_len;
        r_idx     <= '0;
        r_len_err <= w_len_over;
      end
      if (r_state == WAIT_DATA && bus.in_valid) r_data <= bus.in_data;
      if (r_state == WAIT_DONE && bus.mem_done) r_idx  <= w_idx_inc;
    end
  end

  // outputs decoded from state; address/data hold from registers through WAIT_DONE
  always_comb begin
    bus.in_ready       = (r_state == WAIT_DATA);
    bus.mem_write_en   = (r_state == WRITE);
    bus.done           = (r_state == FINISH);
    bus.busy           = (r_state != IDLE);
    bus.len_err        = r_len_err;
    bus.mem_addr0      = r_idx[IDX_SIZE-1:0];
    bus.mem_write_data = r_data;
  end
endmodule

// File: tb/tb_std_mem_d1_loader.sv
// Directed bench: loader driving a real std_mem_d1, checked each cycle against a word-level model.
module tb_std_mem_d1_loader;
  localparam int WIDTH    = 32;
  localparam int SIZE     = 16;
  localparam int IDX_SIZE = 4;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             mem_rst = 1'b1;
  logic [WIDTH-1:0] rd_data;

  std_mem_d1_loader_if #(.WIDTH(WIDTH), .IDX_SIZE(IDX_SIZE)) bus ();

  std_mem_d1_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  std_mem_d1 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) u_mem (
    .clk(clk), .reset(mem_rst), .addr0(bus.mem_addr0), .write_data(bus.mem_write_data),
    .write_en(bus.mem_write_en), .read_data(rd_data), .done(bus.mem_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int we_cnt, rdy_cnt, busy_cnt, stall_cnt, done_cnt = 0, done_rel = -1, go_cyc = 0;
  logic [WIDTH-1:0] src_q[$];
  int               src_gap[$];

  // ---------------- word-level reference model ----------------
  // A load is "words written so far" plus which part of the current word is in flight:
  // holding a captured word (write this cycle), or waiting for the memory's done echo.
  bit               m_act = 0, m_have = 0, m_wait = 0, m_fin = 0, m_err = 0, m_memdone = 0;
  int               m_n = 0, m_k = 0;
  logic [WIDTH-1:0] m_word = '0;
  logic [WIDTH-1:0] exp_mem [SIZE];

  always @(posedge clk) begin
    if (m_have) exp_mem[m_k] <= m_word;      // memory completes a strobe even under loader reset
    m_memdone <= m_have;
    if (!reset_n) begin
      m_act <= 0; m_have <= 0; m_wait <= 0; m_fin <= 0; m_err <= 0;
      m_k <= 0; m_n <= 0; m_word <= '0;
    end else if (m_fin) begin
      m_fin <= 0; m_act <= 0;
    end else if (!m_act) begin
      if (bus.go) begin
        m_n   <= (int'(bus.len) > SIZE) ? SIZE : int'(bus.len);
        m_err <= int'(bus.len) > SIZE;
        m_k   <= 0;
        m_act <= 1;
        m_fin <= (bus.len == 0);
      end
    end else if (m_have) begin
      m_have <= 0; m_wait <= 1;
    end else if (m_wait) begin
      if (m_memdone) begin
        m_wait <= 0;
        m_k    <= m_k + 1;
        if (m_k + 1 == m_n) m_fin <= 1;
      end
    end else if (bus.in_valid) begin
      m_word <= bus.in_data; m_have <= 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input int gap);
    src_q.push_back(d); src_gap.push_back(gap);
  endtask

  task automatic begin_test(input int n);
    we_cnt = 0; rdy_cnt = 0; busy_cnt = 0; stall_cnt = 0;
    bus.go = 1'b1; bus.len = (IDX_SIZE+1)'(n); go_cyc = cyc;
  endtask

  task automatic wait_done(input int base, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (done_cnt > base) return;
    end
    chk("done_timeout", 64'(done_cnt), 64'(base + 1));
  endtask

  initial begin
    bus.go = 0; bus.len = '0; bus.in_valid = 0; bus.in_data = '0;
    fork
      // compare process: every cycle after the first edge
      forever begin
        @(negedge clk);
        if (cyc > 0) begin
          chk("in_ready", bus.in_ready,       m_act && !m_have && !m_wait && !m_fin);
          chk("write_en", bus.mem_write_en,   m_have);
          chk("addr0",    bus.mem_addr0,      64'(m_k % SIZE));
          chk("wdata",    bus.mem_write_data, m_word);
          chk("done",     bus.done,           m_fin);
          chk("busy",     bus.busy,           m_act || m_fin);
          chk("len_err",  bus.len_err,        m_err);
          if (bus.mem_write_en) we_cnt++;
          if (bus.in_ready)     rdy_cnt++;
          if (bus.busy)         busy_cnt++;
          if (bus.done) begin done_cnt++; done_rel = cyc - go_cyc; end
        end
      end
      // stream source: gap = idle cycles before a word is offered once it reaches the front
      forever begin
        bit hs;
        @(posedge clk);
        hs = bus.in_valid && bus.in_ready && reset_n;
        if (bus.in_ready && !bus.in_valid) stall_cnt++;
        @(negedge clk);
        if (hs && src_q.size() > 0) begin void'(src_q.pop_front()); void'(src_gap.pop_front()); end
        if (src_q.size() > 0 && src_gap[0] == 0) begin
          bus.in_valid = 1'b1; bus.in_data = src_q[0];
        end else begin
          bus.in_valid = 1'b0;
          if (src_q.size() > 0) src_gap[0]--;
        end
      end
      // directed stimulus
      begin
        int base;
        repeat (3) tick();
        reset_n = 1'b1; mem_rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_len_err", bus.len_err, 0);

        // 4 words, valid always high
        tick();
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 0);
        base = done_cnt; begin_test(4);
        tick(); bus.go = 0;
        wait_done(base, 60);
        chk("t1_done_cycle", 64'(done_rel), 13);
        chk("t1_done_width", bus.done, 0);
        chk("t1_writes", 64'(we_cnt), 4);
        for (int i = 0; i < 4; i++) chk("t1_mem", u_mem.mem[i], 32'hA0 + 32'(i));

        // 3 words, 5 idle cycles before the third
        tick();
        push(32'hB0, 0); push(32'hB1, 0); push(32'hB2, 5);
        base = done_cnt; begin_test(3);
        tick(); bus.go = 0;
        wait_done(base, 60);
        chk("t2_done_cycle", 64'(done_rel), 13);
        chk("t2_writes", 64'(we_cnt), 3);
        chk("t2_stall_ready", 64'(stall_cnt), 3);
        for (int i = 0; i < 3; i++) chk("t2_mem", u_mem.mem[i], 32'hB0 + 32'(i));

        // len 20 clamps to 16 and raises len_err
        tick();
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 0);
        base = done_cnt; begin_test(20);
        tick(); bus.go = 0;
        chk("t3_len_err", bus.len_err, 1);
        wait_done(base, 120);
        chk("t3_done_cycle", 64'(done_rel), 49);
        chk("t3_writes", 64'(we_cnt), 16);
        for (int i = 0; i < 16; i++) chk("t3_mem", u_mem.mem[i], 32'h100 + 32'(i));

        // back-to-back: go held through done, len_err clears on the new go
        tick();
        chk("t6_err_sticky", bus.len_err, 1);
        for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i), 0);
        base = done_cnt; begin_test(2);
        tick();
        chk("t6_err_clear", bus.len_err, 0);
        wait_done(base, 40);
        chk("t6_first_done", 64'(done_rel), 7);
        base = done_cnt;
        tick(); bus.go = 0;
        wait_done(base, 40);
        chk("t6_second_done", 64'(done_rel), 15);
        chk("t6_writes", 64'(we_cnt), 4);
        chk("t6_mem0", u_mem.mem[0], 32'hC2);
        chk("t6_mem1", u_mem.mem[1], 32'hC3);

        // len 0: straight to done
        tick();
        base = done_cnt; begin_test(0);
        tick(); bus.go = 0;
        wait_done(base, 20);
        chk("t4_done_cycle", 64'(done_rel), 1);
        chk("t4_busy_cycles", 64'(busy_cnt), 1);
        chk("t4_ready_cycles", 64'(rdy_cnt), 0);
        chk("t4_writes", 64'(we_cnt), 0);

        // reset while waiting on the second word's done, then reload
        tick();
        for (int i = 0; i < 5; i++) push(32'hD0 + 32'(i), 0);
        begin_test(5);
        tick(); bus.go = 0;
        repeat (5) tick();
        chk("t5_pre_busy", bus.busy, 1);
        chk("t5_pre_addr", bus.mem_addr0, 1);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_ready", bus.in_ready, 0);
        chk("t5_rst_we", bus.mem_write_en, 0);
        chk("t5_rst_addr", bus.mem_addr0, 0);
        chk("t5_rst_data", bus.mem_write_data, 0);
        chk("t5_rst_done", bus.done, 0);
        reset_n = 1'b1;
        src_q.delete(); src_gap.delete();
        chk("t5_kept_word1", u_mem.mem[1], 32'hD1);
        tick();
        for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i), 0);
        base = done_cnt; begin_test(3);
        tick(); bus.go = 0;
        wait_done(base, 40);
        chk("t5_done_cycle", 64'(done_rel), 10);
        chk("t5_writes", 64'(we_cnt), 3);
        for (int i = 0; i < 3; i++) chk("t5_mem", u_mem.mem[i], 32'hE0 + 32'(i));
        repeat (2) tick();
      end
    join_any
    for (int i = 0; i < SIZE; i++) chk("final_mem", u_mem.mem[i], exp_mem[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
